// File: rtl/snoop_bus_arbiter.sv
// rtl/snoop_bus_arbiter.sv - round-robin snoop bus arbiter with memory/write-back sequencing
//
// Purpose: grants one of four processors the snoop bus, broadcasts its command,
// resolves the snoop response and, when needed, performs a memory read or a
// write-back before pulsing done to the requester. One transaction at a time.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req[3:0], req_cmd[11:0]    per-processor request and 3-bit command
//   grant[3:0], processor[1:0] one-hot owner and its index
//   bus[2:0]                   command broadcast during the snoop cycle
//   snoop_hit/wb/abort, snoop_data[7:0]  OR-reduced snooper responses
//   mem_req, mem_we, mem_wdata[7:0], mem_ack, mem_rdata[7:0]  memory port
//   data_out[7:0], done[3:0]   fill data and one-cycle completion pulse
//   error                      timeout flag
//
// Optional feature: define SNOOP_TIMEOUT_EN to abandon a memory access after
// 15 cycles without mem_ack (done with error=1, data_out=0).

module snoop_bus_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [11:0] req_cmd,
  output logic [3:0]  grant,
  output logic [2:0]  bus,
  output logic [1:0]  processor,
  input  logic        snoop_hit,
  input  logic        snoop_wb,
  input  logic        snoop_abort,
  input  logic [7:0]  snoop_data,
  output logic        mem_req,
  output logic        mem_we,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  data_out,
  output logic [3:0]  done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, SNOOP, MEM, WB, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cmd_q;
  logic [3:0]  grant_q;
  logic [1:0]  proc_q;
  logic [1:0]  ptr_q;
  logic [7:0]  data_q;
  logic [7:0]  wdata_q;
  logic        win_valid;
  logic [1:0]  win_idx;
  logic [1:0]  cand;
  logic        mem_cmd;
  logic        legal_cmd;
  logic        timeout;
  logic        unused_hit;

  // snoop_hit carries no control meaning here; it is visible on the port only.
  assign unused_hit = snoop_hit;

  assign mem_cmd   = (cmd_q == 3'b001) || (cmd_q == 3'b010);
  assign legal_cmd = mem_cmd || (cmd_q == 3'b011);

  // Round-robin search starts one past the last winner; offset 4 wraps to the
  // last winner itself so a lone repeat requester is still served.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = ptr_q + i[1:0];
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

`ifdef SNOOP_TIMEOUT_EN
  logic [3:0] cnt_q;
  logic       err_q;

  // Counter is 0 in the first MEM/WB cycle, so cnt_q==14 marks the 15th wait cycle.
  assign timeout = !mem_ack && (cnt_q == 4'd14);
  assign error   = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      if (state_q == MEM || state_q == WB)
        cnt_q <= cnt_q + 4'd1;
      else
        cnt_q <= 4'd0;
      err_q <= (state_q == MEM || state_q == WB) && timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (win_valid) state_d = SNOOP;
      SNOOP: begin
        if (!mem_cmd)         state_d = DONE;
        else if (!snoop_abort) state_d = MEM;
        else if (snoop_wb)    state_d = WB;
        else                  state_d = DONE;
      end
      MEM, WB: if (mem_ack || timeout) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cmd_q   <= 3'b000;
      grant_q <= 4'b0000;
      proc_q  <= 2'd0;
      ptr_q   <= 2'd3;
      data_q  <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_d == DONE && state_q != DONE)
        ptr_q <= proc_q;
      case (state_q)
        IDLE: begin
          if (win_valid) begin
            grant_q <= 4'b0001 << win_idx;
            proc_q  <= win_idx;
            cmd_q   <= req_cmd[win_idx*3 +: 3];
          end
        end
        SNOOP: begin
          wdata_q <= snoop_data;
          data_q  <= (mem_cmd && snoop_abort) ? snoop_data : 8'h00;
        end
        MEM, WB: begin
          // Write-back keeps the snooped data as the fill value.
          if (mem_ack) begin
            if (state_q == MEM) data_q <= mem_rdata;
          end else if (timeout) begin
            data_q <= 8'h00;
          end
        end
        DONE:    grant_q <= 4'b0000;
        default: grant_q <= 4'b0000;
      endcase
    end
  end

  assign grant     = grant_q;
  assign processor = proc_q;
  assign bus       = (state_q == SNOOP && legal_cmd) ? cmd_q : 3'b000;
  assign mem_req   = (state_q == MEM) || (state_q == WB);
  assign mem_we    = (state_q == WB);
  assign mem_wdata = wdata_q;
  assign data_out  = data_q;
  assign done      = (state_q == DONE) ? grant_q : 4'b0000;

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// tb/tb_snoop_bus_arbiter.sv - self-checking bench for snoop_bus_arbiter
module tb_snoop_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [11:0] req_cmd;
  logic [3:0]  grant;
  logic [2:0]  bus;
  logic [1:0]  processor;
  logic        snoop_hit, snoop_wb, snoop_abort;
  logic [7:0]  snoop_data;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_rdata, mem_wdata, data_out;
  logic [3:0]  done;
  logic        error;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  snoop_bus_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .req_cmd(req_cmd),
    .grant(grant), .bus(bus), .processor(processor),
    .snoop_hit(snoop_hit), .snoop_wb(snoop_wb), .snoop_abort(snoop_abort),
    .snoop_data(snoop_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
    .data_out(data_out), .done(done), .error(error)
  );

  typedef struct {
    logic [3:0]  req;
    logic [11:0] cmd;
    logic        abort;
    logic        wb;
    logic [7:0]  sdata;
    logic [7:0]  rdata;
    int          delay;
    logic [3:0]  egrant;
    logic [1:0]  eproc;
    logic [2:0]  ebus;
    int          path;   // 0 no memory, 1 memory read, 2 write-back
    logic [7:0]  edata;
  } vec_t;

  vec_t v [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " grant"}, grant, 0);
    chk({tag, " bus"}, bus, 0);
    chk({tag, " processor"}, processor, 0);
    chk({tag, " mem_req"}, mem_req, 0);
    chk({tag, " mem_we"}, mem_we, 0);
    chk({tag, " mem_wdata"}, mem_wdata, 0);
    chk({tag, " data_out"}, data_out, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " error"}, error, 0);
  endtask

  task automatic run_vec(input int i);
    string t;
    t = $sformatf("v%0d", i);
    req = v[i].req; req_cmd = v[i].cmd;
    snoop_abort = v[i].abort; snoop_wb = v[i].wb; snoop_data = v[i].sdata;
    step();
    chk({t, " grant"}, grant, v[i].egrant);
    chk({t, " processor"}, processor, v[i].eproc);
    chk({t, " bus"}, bus, v[i].ebus);
    chk({t, " snoop mem_req"}, mem_req, 0);
    step();
    snoop_data = 8'h00; snoop_abort = 1'b0; snoop_wb = 1'b0;
    if (v[i].path != 0) begin
      for (int c = 0; c <= v[i].delay; c++) begin
        chk({t, " mem_req"}, mem_req, 1);
        chk({t, " mem_we"}, mem_we, (v[i].path == 2));
        if (v[i].path == 2) chk({t, " mem_wdata"}, mem_wdata, v[i].sdata);
        chk({t, " early done"}, done, 0);
        if (c == v[i].delay) begin
          mem_ack = 1'b1; mem_rdata = v[i].rdata;
        end else begin
          mem_rdata = 8'hEE;
        end
        step();
        mem_ack = 1'b0;
      end
    end
    chk({t, " done"}, done, v[i].egrant);
    chk({t, " data_out"}, data_out, v[i].edata);
    chk({t, " grant held"}, grant, v[i].egrant);
    chk({t, " done mem_req"}, mem_req, 0);
    chk({t, " error"}, error, 0);
    req = 4'b0000;
    step();
    chk({t, " idle grant"}, grant, 0);
    chk({t, " idle done"}, done, 0);
  endtask

  logic [3:0] rr_exp [5];

  initial begin
    reset = 1'b1; req = 0; req_cmd = 0; snoop_hit = 0; snoop_wb = 0;
    snoop_abort = 0; snoop_data = 0; mem_ack = 0; mem_rdata = 0;

    //        req     cmd      ab wb sdata  rdata  dly grant   pr bus     path data
    v[0] = '{4'b0001, 12'h003, 0, 0, 8'h00, 8'h00, 0, 4'b0001, 0, 3'b011, 0, 8'h00};
    v[1] = '{4'b0010, 12'h008, 0, 0, 8'h00, 8'hA5, 3, 4'b0010, 1, 3'b001, 1, 8'hA5};
    v[2] = '{4'b0100, 12'h080, 1, 1, 8'h3C, 8'h99, 1, 4'b0100, 2, 3'b010, 2, 8'h3C};
    v[3] = '{4'b1000, 12'h200, 1, 0, 8'h5A, 8'h00, 0, 4'b1000, 3, 3'b001, 0, 8'h5A};
    v[4] = '{4'b0001, 12'h004, 1, 1, 8'hFF, 8'h00, 0, 4'b0001, 0, 3'b000, 0, 8'h00};
    v[5] = '{4'b0011, 12'h019, 1, 1, 8'hEE, 8'h00, 0, 4'b0010, 1, 3'b011, 0, 8'h00};
    v[6] = '{4'b1001, 12'h403, 0, 0, 8'h00, 8'h77, 0, 4'b1000, 3, 3'b010, 1, 8'h77};
    v[7] = '{4'b0110, 12'h058, 0, 0, 8'h00, 8'h00, 0, 4'b0010, 1, 3'b011, 0, 8'h00};

    step(); step();
    chk_reset_outputs("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < 8; i++) run_vec(i);

    // Reset while waiting in MEM drops the transaction without a done pulse.
    req = 4'b0010; req_cmd = 12'h008; snoop_abort = 1'b0;
    step(); step();
    chk("rst mid mem_req", mem_req, 1);
    reset = 1'b1; req = 4'b0000;
    step();
    chk_reset_outputs("rst mid");
    reset = 1'b0;
    step();
    chk("rst after done", done, 0);
    chk("rst after grant", grant, 0);

    // All four held with invalidates: pointer restarts at 3, so processor 0 first.
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    req = 4'b1111; req_cmd = 12'h6DB;
    for (int k = 0; k < 5; k++) begin
      step();
      chk($sformatf("rr%0d grant", k), grant, rr_exp[k]);
      chk($sformatf("rr%0d bus", k), bus, 3'b011);
      step();
      chk($sformatf("rr%0d done", k), done, rr_exp[k]);
      if (k == 4) req = 4'b0000;
      step();
      chk($sformatf("rr%0d idle", k), grant, 0);
    end

    // No mem_ack while in MEM.
    req = 4'b0001; req_cmd = 12'h001; snoop_abort = 1'b0;
    step(); step();
`ifdef SNOOP_TIMEOUT_EN
    for (int c = 0; c < 15; c++) begin
      chk($sformatf("to wait%0d mem_req", c), mem_req, 1);
      chk($sformatf("to wait%0d done", c), done, 0);
      step();
    end
    chk("to done", done, 4'b0001);
    chk("to error", error, 1);
    chk("to data_out", data_out, 0);
    chk("to mem_req", mem_req, 0);
    req = 4'b0000;
    step();
    chk("to error clear", error, 0);
`else
    for (int c = 0; c < 30; c++) begin
      chk($sformatf("hold%0d mem_req", c), mem_req, 1);
      chk($sformatf("hold%0d done", c), done, 0);
      step();
    end
    chk("hold error", error, 0);
    mem_ack = 1'b1; mem_rdata = 8'h42;
    step();
    mem_ack = 1'b0;
    chk("hold done", done, 4'b0001);
    chk("hold data_out", data_out, 8'h42);
    req = 4'b0000;
    step();
    chk("hold idle", grant, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
